// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// iteration count and a small magnitude helper.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          ITERS   = 32;
  localparam int          CNT_W   = 5;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // INT_MIN maps to 0x80000000, which is correct when read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear, count enable, terminal count on the
// last iteration so the controller can leave the iterate state on that edge.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int LAST = ITERS - 1
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) count_q <= '0;
    else            count_q <= count_d;
  end

  assign tc = (count_q == CNT_W'(LAST));

endmodule

// File: rtl/register.sv
// Generic enabled holding register with asynchronous active-high clear.
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (enable) q_d = d;
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) q_q <= '0;
    else            q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring)
// unit, one iteration per clock with fixed latency.
//
// state | meaning
// IDLE  | no operation in flight
// MULT  | Booth iterations running
// DIV   | non-restoring division iterations running
// DONE  | result registered, ready pulse high this cycle
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  import multdiv_pkg::state_e;
  import multdiv_pkg::ST_IDLE;
  import multdiv_pkg::ST_MULT;
  import multdiv_pkg::ST_DIV;
  import multdiv_pkg::ST_DONE;
  import multdiv_pkg::INT_MIN;
  import multdiv_pkg::mag32;

  state_e      state_q, state_d;
  // acc is shared: Booth high half (sign-extended) or division partial remainder
  logic [33:0] acc_q, acc_d;
  logic [31:0] qr_q, qr_d;
  logic [31:0] dvs_q, dvs_d;
  logic        ext_q, ext_d;
  logic        neg_q, neg_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic        rdy_q, rdy_d;

  logic        start, running, tc;
  logic        res_en, exc_d;
  logic [31:0] res_d;

  logic [33:0] booth_sum, m_acc_n, div_shift, div_rem;
  logic [31:0] m_qr_n, d_qr_n, quot, div_res;
  logic [63:0] product;
  logic        mult_exc, div_exc;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign running = (state_q == ST_MULT) || (state_q == ST_DIV);

  always_comb begin
    booth_sum = acc_q;
    case ({qr_q[0], ext_q})
      2'b01:   booth_sum = acc_q + {{2{dvs_q[31]}}, dvs_q};
      2'b10:   booth_sum = acc_q - {{2{dvs_q[31]}}, dvs_q};
      default: booth_sum = acc_q;
    endcase
    m_acc_n  = {booth_sum[33], booth_sum[33:1]};
    m_qr_n   = {booth_sum[0], qr_q[31:1]};
    product  = {m_acc_n[31:0], m_qr_n};
    mult_exc = (product[63:32] != {32{product[31]}});

    div_shift = {acc_q[32:0], qr_q[31]};
    div_rem   = acc_q[33] ? (div_shift + {2'b00, dvs_q}) : (div_shift - {2'b00, dvs_q});
    d_qr_n    = {qr_q[30:0], ~div_rem[33]};
    quot      = neg_q ? (~d_qr_n + 32'd1) : d_qr_n;
    div_res   = dz_q ? 32'd0 : (ovf_q ? INT_MIN : quot);
    div_exc   = dz_q | ovf_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    dvs_d   = dvs_q;
    ext_d   = ext_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    rdy_d   = 1'b0;
    res_en  = 1'b0;
    res_d   = '0;
    exc_d   = 1'b0;
    if (start) begin
      acc_d = '0;
      ext_d = 1'b0;
      if (ctrl_MULT) begin
        state_d = ST_MULT;
        qr_d    = data_operandB;
        dvs_d   = data_operandA;
        neg_d   = 1'b0;
        dz_d    = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        state_d = ST_DIV;
        qr_d    = mag32(data_operandA);
        dvs_d   = mag32(data_operandB);
        neg_d   = data_operandA[31] ^ data_operandB[31];
        dz_d    = (data_operandB == 32'd0);
        ovf_d   = (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
      end
    end else begin
      case (state_q)
        ST_MULT: begin
          acc_d = m_acc_n;
          qr_d  = m_qr_n;
          ext_d = qr_q[0];
          if (tc) begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
            res_en  = 1'b1;
            res_d   = product[31:0];
            exc_d   = mult_exc;
          end
        end
        ST_DIV: begin
          acc_d = div_rem;
          qr_d  = d_qr_n;
          if (tc) begin
            state_d = ST_DONE;
            rdy_d   = 1'b1;
            res_en  = 1'b1;
            res_d   = div_res;
            exc_d   = div_exc;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      qr_q    <= '0;
      dvs_q   <= '0;
      ext_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      dvs_q   <= dvs_d;
      ext_q   <= ext_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  multdiv_counter #(.LAST(ITERS - 1)) u_cnt (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .clr        (start),
    .en         (running),
    .tc         (tc)
  );

  register #(.WIDTH(32)) u_res (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .enable     (res_en),
    .d          (res_d),
    .q          (data_result)
  );

  register #(.WIDTH(1)) u_exc (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .enable     (res_en),
    .d          (exc_d),
    .q          (data_exception)
  );

  assign data_resultRDY = rdy_q;
  assign data_busy      = running | start;

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage.
- Consumes operands and control decoded from the D/X latch outputs.
- Raises data_busy so hazard logic freezes the F/D and D/X latch enables.
- Returns a result with a one-cycle ready pulse; the result feeds the X/M latch.
- Radix-2: one iteration per clock, fixed latency, independent of operand values.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported.
- ITERS, 32, iterations per operation. Must equal WIDTH.

Ports:
- clock  input  1  rising-edge clock
- ctrl_reset  input  1  asynchronous, active-high reset
- data_operandA  input  32  multiplicand / dividend, signed two's complement
- data_operandB  input  32  multiplier / divisor, signed two's complement
- ctrl_MULT  input  1  start-multiply request, sampled each rising edge
- ctrl_DIV  input  1  start-divide request, sampled each rising edge
- data_result  output  32  low 32 bits of product, or quotient
- data_exception  output  1  overflow or divide-by-zero flag for the completed op
- data_resultRDY  output  1  one-cycle pulse: result and exception valid
- data_busy  output  1  high while an operation is in progress

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high, with the clock port named clock and the reset port named ctrl_reset.
- Reset values: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, data_busy=0, all internal registers 0.
- States: IDLE, MULT, DIV, DONE.
- Start: at any edge where ctrl_MULT or ctrl_DIV is high, in any state, the operands are captured, the counter is cleared and the state goes to MULT or DIV.
  - Both high at once: treated as MULT.
  - Start while MULT/DIV: aborts the current op and restarts with the new operands. No RDY is produced for the aborted op.
- Operands are sampled only at the start edge. Later changes on the inputs are ignored.
- Iteration: in MULT/DIV, each edge performs one iteration and increments the counter. The edge that completes iteration ITERS moves the state to DONE.
- MULT algorithm:
  - Radix-2 Booth on a 65-bit {product, multiplier, extra} register.
  - Product is the low 32 bits.
  - Exception = 1 when the 64-bit product's high 32 bits are not all equal to product bit 31.
- DIV algorithm:
  - Non-restoring division on magnitudes, then sign correction.
  - Quotient truncates toward zero (-7/2 = -3). Remainder is discarded.
- DIV boundary cases (still full latency):
  - Divisor 0: result 0, exception 1.
  - 0x80000000 / -1: result 0x80000000, exception 1.
- DONE:
  - data_resultRDY=1 for exactly this cycle.
  - data_result and data_exception update on entry to DONE. They hold until the next DONE or reset.
  - Next edge goes to IDLE, unless a start is present.
- Latency: start sampled at edge E0; iterations at E1..E32; RDY is high in the cycle after E32, for that cycle only.
- data_busy: high in MULT and DIV, and combinationally high in any cycle where ctrl_MULT or ctrl_DIV is asserted. Low in IDLE and DONE otherwise.
- Reset asserted mid-operation: immediately returns to IDLE with reset values. No RDY is produced.

Decomposition:
- Shared package (multdiv_pkg):
  - state encoding constants (IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3)
  - ITERS, INT_MIN = 32'h80000000
- Sub-modules:
  - Result and exception holding registers use the existing register module (clock, ctrl_reset, enable, d, q).
  - One new sub-module, multdiv_counter: 5-bit iteration counter with clear, enable and terminal-count output.

Test Plan:
- Multiply 7 × -6 -> data_result=0xFFFFFFD6, exception 0, RDY high exactly one cycle, 33 cycles after the start cycle. data_busy is high from the start cycle through the cycle before RDY.
- Multiply 0x00010000 × 0x00010000 -> data_result=0x00000000, exception 1. Then 0x7FFFFFFF × 1 -> 0x7FFFFFFF, exception 0.
- Divide -7 ÷ 2 -> 0xFFFFFFFD, exception 0. Then 100 ÷ -7 -> 0xFFFFFFF2, exception 0.
- Divide 5 ÷ 0 -> result 0, exception 1, same latency. Then 0x80000000 ÷ 0xFFFFFFFF -> result 0x80000000, exception 1.
- Restart: start 3×4, assert ctrl_DIV with 9÷3 at iteration 10 -> a single RDY, 33 cycles after the DIV start cycle, with result 3.
- Reset at iteration 10 of a multiply -> outputs return to 0 asynchronously, no RDY pulse follows. The next multiply 2×3 returns 6 normally.
- Both ctrl_MULT and ctrl_DIV high with 6, 3 -> result 18 (treated as MULT).
